// File: rtl/tile_psum_accumulator.sv
// tile_psum_accumulator
// Sums cfg_tiles consecutive Tn-lane partial-sum vectors per output pixel,
// saturates each lane to FEATURE_WIDTH and queues the pixel result in a
// 2-entry in-order valid/ready buffer. The input is never back-pressured:
// a result that finds the buffer full is dropped and flagged as overflow.
module tile_psum_accumulator #(
    parameter int Tn            = 4,
    parameter int FEATURE_WIDTH = 16,
    parameter int ACC_WIDTH     = FEATURE_WIDTH + 8,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                          fast_clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic [CNT_WIDTH-1:0]          cfg_tiles,
    input  logic [CNT_WIDTH-1:0]          cfg_pixels,
    input  logic                          in_valid,
    input  logic [Tn*FEATURE_WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [Tn*FEATURE_WIDTH-1:0]   out_data,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    localparam int DW = Tn * FEATURE_WIDTH;

    // Saturation bounds expressed at accumulator width for signed compares.
    localparam logic [ACC_WIDTH-1:0] SAT_MAX_ACC =
        {{(ACC_WIDTH-FEATURE_WIDTH+1){1'b0}}, {(FEATURE_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN_ACC =
        {{(ACC_WIDTH-FEATURE_WIDTH+1){1'b1}}, {(FEATURE_WIDTH-1){1'b0}}};
    localparam logic [FEATURE_WIDTH-1:0] SAT_MAX_FW = {1'b0, {(FEATURE_WIDTH-1){1'b1}}};
    localparam logic [FEATURE_WIDTH-1:0] SAT_MIN_FW = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Architectural state
    state_t                          state_q,    state_d;
    logic [CNT_WIDTH-1:0]            tiles_q,    tiles_d;
    logic [CNT_WIDTH-1:0]            pixels_q,   pixels_d;
    logic [CNT_WIDTH-1:0]            tile_idx_q, tile_idx_d;
    logic [CNT_WIDTH-1:0]            pix_cnt_q,  pix_cnt_d;
    logic [Tn-1:0][ACC_WIDTH-1:0]    acc_q,      acc_d;
    logic [DW-1:0]                   head_q,     head_d;
    logic [DW-1:0]                   tail_q,     tail_d;
    logic [1:0]                      count_q,    count_d;
    logic                            overflow_q, overflow_d;
    logic                            done_q,     done_d;

    // Datapath / control intermediates
    logic [Tn-1:0][ACC_WIDTH-1:0]    lane_ext;
    logic [Tn-1:0][ACC_WIDTH-1:0]    lane_sum;
    logic [DW-1:0]                   sat_data;
    logic                            first_tile;
    logic                            last_tile;
    logic                            last_pixel;
    logic                            accept;
    logic                            push;
    logic                            pop;

    assign first_tile = (tile_idx_q == '0);
    assign last_tile  = (tile_idx_q == tiles_q - 1'b1);
    assign last_pixel = (pix_cnt_q == pixels_q - 1'b1);
    assign accept     = (state_q == ACC) && in_valid && !cfg_start;
    assign pop        = out_valid && out_ready;

    // Per-lane sign extension, tile accumulation (wrapping) and saturation.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        lane_ext = '0;
        lane_sum = '0;
        sat_data = '0;
        for (int i = 0; i < Tn; i++) begin
            lane_ext[i] = {{(ACC_WIDTH-FEATURE_WIDTH){in_data[i*FEATURE_WIDTH+FEATURE_WIDTH-1]}},
                           in_data[i*FEATURE_WIDTH +: FEATURE_WIDTH]};
            lane_sum[i] = (first_tile ? '0 : acc_q[i]) + lane_ext[i];
            if ($signed(lane_sum[i]) > $signed(SAT_MAX_ACC)) begin
                sat_data[i*FEATURE_WIDTH +: FEATURE_WIDTH] = SAT_MAX_FW;
            end else if ($signed(lane_sum[i]) < $signed(SAT_MIN_ACC)) begin
                sat_data[i*FEATURE_WIDTH +: FEATURE_WIDTH] = SAT_MIN_FW;
            end else begin
                sat_data[i*FEATURE_WIDTH +: FEATURE_WIDTH] = lane_sum[i][FEATURE_WIDTH-1:0];
            end
        end
    end

    // Next-state: run control, tile/pixel counters, accumulators and the output buffer.
    always_comb begin
        state_d    = state_q;
        tiles_d    = tiles_q;
        pixels_d   = pixels_q;
        tile_idx_d = tile_idx_q;
        pix_cnt_d  = pix_cnt_q;
        acc_d      = acc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        push       = 1'b0;

        if (cfg_start) begin
            // A start (from IDLE or mid-run) discards everything in flight,
            // including a last-tile push and any in_valid in this cycle.
            tiles_d    = (cfg_tiles  == '0) ? CNT_WIDTH'(1) : cfg_tiles;
            pixels_d   = (cfg_pixels == '0) ? CNT_WIDTH'(1) : cfg_pixels;
            tile_idx_d = '0;
            pix_cnt_d  = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = 2'd0;
            overflow_d = 1'b0;
            state_d    = ACC;
        end else begin
            if (accept) begin
                acc_d = lane_sum;
                if (last_tile) begin
                    push       = 1'b1;
                    tile_idx_d = '0;
                    pix_cnt_d  = pix_cnt_q + 1'b1;
                    if (last_pixel) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tile_idx_d = tile_idx_q + 1'b1;
                end
            end

            // Two-register FIFO: head_q always feeds out_data directly.
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d  = sat_data;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        tail_d  = sat_data;
                        count_d = 2'd2;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = sat_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = sat_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge fast_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tiles_q    <= CNT_WIDTH'(1);
            pixels_q   <= CNT_WIDTH'(1);
            tile_idx_q <= '0;
            pix_cnt_q  <= '0;
            // NOTE: the buffer and accumulators are few enough registers to reset, so out_data is 0 from reset.
            acc_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            tiles_q    <= tiles_d;
            pixels_q   <= pixels_d;
            tile_idx_q <= tile_idx_d;
            pix_cnt_q  <= pix_cnt_d;
            acc_q      <= acc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign busy      = (state_q == ACC);
    assign done      = done_q;
    assign overflow  = overflow_q;

    // Buffer occupancy can never exceed its two entries.
    a_count_range: assert property (@(posedge fast_clk) disable iff (!rst) count_q != 2'd3);

endmodule

// File: tb/tb_tile_psum_accumulator.sv
// Directed bench for tile_psum_accumulator: stimulus pushes expected pixel
// results into a scoreboard queue; a negedge monitor pops and compares every
// beat the DUT hands over (out_valid && out_ready).
module tb_tile_psum_accumulator;

    localparam int TN  = 4;
    localparam int FW  = 16;
    localparam int CW  = 16;
    localparam int DW  = TN * FW;

    logic           fast_clk;
    logic           rst;
    logic           cfg_start;
    logic [CW-1:0]  cfg_tiles;
    logic [CW-1:0]  cfg_pixels;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic           busy;
    logic           done;
    logic           overflow;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [DW-1:0]  exp_q[$];

    tile_psum_accumulator #(
        .Tn            (TN),
        .FEATURE_WIDTH (FW),
        .ACC_WIDTH     (FW + 8),
        .CNT_WIDTH     (CW)
    ) dut (
        .fast_clk   (fast_clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_tiles  (cfg_tiles),
        .cfg_pixels (cfg_pixels),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] vec4(input int a, input int b, input int c, input int d);
        logic [DW-1:0] v;
        v[15:0]  = a[15:0];
        v[31:16] = b[15:0];
        v[47:32] = c[15:0];
        v[63:48] = d[15:0];
        return v;
    endfunction

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge fast_clk);
        #1;
    endtask

    // One-cycle cfg_start; optionally with a junk in_valid beat that must be ignored.
    task automatic start(input int tiles, input int pixels, input logic junk_valid);
        cfg_start  = 1'b1;
        cfg_tiles  = tiles[CW-1:0];
        cfg_pixels = pixels[CW-1:0];
        in_valid   = junk_valid;
        in_data    = vec4(9999, 9999, 9999, 9999);
        cyc();
        cfg_start  = 1'b0;
        in_valid   = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic send(input logic [DW-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        cyc();
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare every delivered beat against the queue head.
    always @(negedge fast_clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, expected no output", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        cfg_start  = 1'b0;
        cfg_tiles  = '0;
        cfg_pixels = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data",  out_data,          64'd0);
        check("rst_busy",      {63'd0, busy},     64'd0);
        check("rst_done",      {63'd0, done},     64'd0);
        check("rst_overflow",  {63'd0, overflow}, 64'd0);
        rst = 1'b1;
        cyc();

        // 1. Basic accumulation over three tiles.
        start(3, 1, 1'b0);
        send(vec4(1, 2, 3, 4));
        send(vec4(10, 20, 30, 40));
        exp_q.push_back(vec4(111, 222, 333, 444));
        send(vec4(100, 200, 300, 400));
        check("t1_out_valid", {63'd0, out_valid}, 64'd1);
        check("t1_done",      {63'd0, done},      64'd1);
        check("t1_busy_low",  {63'd0, busy},      64'd0);
        cyc();
        check("t1_done_pulse", {63'd0, done}, 64'd0);
        cyc();

        // 2. Saturation at both rails plus in-range lanes.
        start(2, 1, 1'b0);
        exp_q.push_back(vec4(32767, -32768, 32767, -2));
        send(vec4(30000, -30000, 32767, -5));
        send(vec4(30000, -30000, 0, 3));
        cyc();
        cyc();

        // 3. Back-pressure: third result dropped, first two delivered in order.
        out_ready = 1'b0;
        start(1, 3, 1'b0);
        exp_q.push_back(vec4(1, 1, 1, 1));
        exp_q.push_back(vec4(2, 2, 2, 2));
        send(vec4(1, 1, 1, 1));
        send(vec4(2, 2, 2, 2));
        send(vec4(3, 3, 3, 3));
        check("t3_overflow",  {63'd0, overflow}, 64'd1);
        check("t3_done",      {63'd0, done},     64'd1);
        cyc();
        check("t3_hold_data", out_data, vec4(1, 1, 1, 1));
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        check("t3_drained", {63'd0, out_valid}, 64'd0);

        // 4. Zero config maps to one tile, one pixel.
        start(0, 0, 1'b0);
        check("t4_overflow_cleared", {63'd0, overflow}, 64'd0);
        exp_q.push_back(vec4(7, -7, 0, 1));
        send(vec4(7, -7, 0, 1));
        check("t4_done", {63'd0, done}, 64'd1);
        check("t4_busy", {63'd0, busy}, 64'd0);
        cyc();
        cyc();

        // 5. Aborts: a full buffer with overflow, then a mid-tile abort with bubbles.
        out_ready = 1'b0;
        start(1, 4, 1'b0);
        send(vec4(11, 11, 11, 11));
        send(vec4(12, 12, 12, 12));
        send(vec4(13, 13, 13, 13));
        check("t5_pre_overflow", {63'd0, overflow}, 64'd1);
        start(4, 2, 1'b1);
        check("t5_overflow_cleared", {63'd0, overflow},  64'd0);
        check("t5_buffer_flushed",   {63'd0, out_valid}, 64'd0);
        send(vec4(5, 5, 5, 5));
        cyc();
        send(vec4(6, 6, 6, 6));
        cyc();
        start(2, 1, 1'b1);
        out_ready = 1'b1;
        exp_q.push_back(vec4(999, -1998, 30003, 0));
        send(vec4(1000, -2000, 3, 4));
        cyc();
        send(vec4(-1, 2, 30000, -4));
        check("t5_out_valid", {63'd0, out_valid}, 64'd1);
        check("t5_done",      {63'd0, done},      64'd1);
        cyc();
        cyc();

        // 6. Asynchronous reset with two buffered entries.
        out_ready = 1'b0;
        start(1, 4, 1'b0);
        send(vec4(21, 21, 21, 21));
        send(vec4(22, 22, 22, 22));
        check("t6_full_valid", {63'd0, out_valid}, 64'd1);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("t6_rst_out_data",  out_data,          64'd0);
        check("t6_rst_busy",      {63'd0, busy},     64'd0);
        check("t6_rst_done",      {63'd0, done},     64'd0);
        check("t6_rst_overflow",  {63'd0, overflow}, 64'd0);
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        cyc();
        send(vec4(50, 50, 50, 50));
        send(vec4(51, 51, 51, 51));
        check("t6_idle_ignores_valid", {63'd0, out_valid}, 64'd0);
        check("t6_idle_busy",          {63'd0, busy},      64'd0);
        start(1, 1, 1'b0);
        exp_q.push_back(vec4(-300, 300, -1, 32767));
        send(vec4(-300, 300, -1, 32767));
        check("t6_done", {63'd0, done}, 64'd1);
        cyc();
        cyc();
        cyc();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
